tv_sequencer: RTL and testbench

- Parametrised successor to the fixed 8-bit test-vector store and result-compare path in the test system top.
- Holds DEPTH vectors, each with a drive pattern, an expected response and a compare mask.
- Replays vectors onto the DUT digital I/O, realigns the sampled response for a programmable pipeline latency, and compares under mask.
- Counts errors and loops per test_mode / max_cycles.
- Sits between ConfigParser (vector load, start) and Test_FSM / Result_Analyzer (done, pass, error statistics).

---
 rtl/tv_sequencer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_tv_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tv_sequencer.sv
// tv_sequencer: test-vector store, replay and masked result compare.
//
// The memory holds DEPTH vectors. Each vector has a drive pattern, an
// expected response and a compare mask. A test replays one address per
// cycle onto o_dut_dio. The sampled response is lined up with the
// expected data and mask through a LAT-deep shift register. Mismatching
// vectors are counted, and the test loops according to i_test_mode.
//
// Optional build macro: TV_FAIL_CAPTURE_EN
//   When defined, o_fail_resp and o_fail_expect are added. They hold the
//   response and the expected data of the first failing vector.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_wr_en/addr/drive/expect/mask  vector write port (IDLE only)
//   i_start, i_abort           test control pulses
//   i_test_mode                0 single, 1 max_cycles passes,
//                              2 stop on first error, 3 run until abort
//   i_num_vectors              vectors per pass (0..DEPTH)
//   i_max_cycles               pass count for mode 1 (0 acts as 1)
//   i_dut_resp                 sampled DUT response
//   o_dut_dio                  drive pattern to the DUT
//   o_busy, o_test_done        status, one-cycle completion pulse
//   o_pass, o_aborted          result of the last test
//   o_error_count              saturating count of mismatching vectors
//   o_first_fail_addr          address of the first failing vector
//   o_pass_count               completed passes
module tv_sequencer #(
  parameter int CH_W   = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int LAT    = 2,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [CH_W-1:0]   i_wr_drive,
  input  logic [CH_W-1:0]   i_wr_expect,
  input  logic [CH_W-1:0]   i_wr_mask,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [1:0]        i_test_mode,
  input  logic [ADDR_W:0]   i_num_vectors,
  input  logic [31:0]       i_max_cycles,
  input  logic [CH_W-1:0]   i_dut_resp,
  output logic [CH_W-1:0]   o_dut_dio,
  output logic              o_busy,
  output logic              o_test_done,
  output logic              o_pass,
  output logic              o_aborted,
  output logic [ERR_W-1:0]  o_error_count,
  output logic [ADDR_W-1:0] o_first_fail_addr,
  output logic [31:0]       o_pass_count
`ifdef TV_FAIL_CAPTURE_EN
  ,
  output logic [CH_W-1:0]   o_fail_resp,
  output logic [CH_W-1:0]   o_fail_expect
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Drain lasts LAT+2 cycles so every issued compare has retired.
  localparam logic [3:0] DRAIN_LAST = 4'(LAT + 1);

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CH_W-1:0]   r_mem_drive [0:DEPTH-1];
  logic [CH_W-1:0]   r_mem_exp   [0:DEPTH-1];
  logic [CH_W-1:0]   r_mem_mask  [0:DEPTH-1];

  logic [CH_W-1:0]   r_dio;
  logic              r_vld_pipe  [0:LAT];
  logic [CH_W-1:0]   r_exp_pipe  [0:LAT];
  logic [CH_W-1:0]   r_mask_pipe [0:LAT];
  logic [ADDR_W-1:0] r_addr_pipe [0:LAT];

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_num;
  logic [1:0]        r_mode;
  logic [31:0]       r_max;
  logic [3:0]        r_drain_cnt;
  logic              r_busy;
  logic              r_test_done;
  logic              r_pass;
  logic              r_aborted;
  logic [ERR_W-1:0]  r_err_count;
  logic [ADDR_W-1:0] r_ffa;
  logic [31:0]       r_pass_count;
`ifdef TV_FAIL_CAPTURE_EN
  logic [CH_W-1:0]   r_fail_resp;
  logic [CH_W-1:0]   r_fail_expect;
`endif

  logic              w_start_ok;
  logic [ADDR_W:0]   w_addr_inc;
  logic              w_pass_end;
  logic [31:0]       w_max_eff;
  logic              w_last_pass;
  logic              w_cmp_fail;
  logic              w_first_fail;
  logic              w_drain_last;

  assign w_start_ok   = (r_state == ST_IDLE) && i_start;
  assign w_addr_inc   = {1'b0, r_addr} + (ADDR_W + 1)'(1);
  assign w_pass_end   = (r_state == ST_RUN) && (w_addr_inc == r_num);
  assign w_max_eff    = (r_max == 32'd0) ? 32'd1 : r_max;
  assign w_last_pass  = ({1'b0, r_pass_count} + 33'd1) >= {1'b0, w_max_eff};
  assign w_cmp_fail   = r_vld_pipe[LAT] &&
                        (|((i_dut_resp ^ r_exp_pipe[LAT]) & r_mask_pipe[LAT]));
  assign w_first_fail = w_cmp_fail && (r_err_count == {ERR_W{1'b0}});
  assign w_drain_last = (r_drain_cnt == DRAIN_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_num_vectors == {(ADDR_W + 1){1'b0}}) w_state_nxt = ST_DONE;
          else                                       w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_first_fail && (r_mode == 2'd2)) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_pass_end) begin
          case (r_mode)
            2'd0, 2'd2: w_state_nxt = ST_DRAIN;
            2'd1:       w_state_nxt = w_last_pass ? ST_DRAIN : ST_RUN;
            default:    w_state_nxt = ST_RUN;
          endcase
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (w_drain_last) w_state_nxt = ST_DONE;
        else              w_state_nxt = ST_DRAIN;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Vector memory write port; only accepted while idle.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && i_wr_en) begin
      r_mem_drive[i_wr_addr] <= i_wr_drive;
      r_mem_exp[i_wr_addr]   <= i_wr_expect;
      r_mem_mask[i_wr_addr]  <= i_wr_mask;
    end
  end

  // Registered read, drive output and expect/mask alignment pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dio <= {CH_W{1'b0}};
      for (int k = 0; k <= LAT; k++) begin
        r_vld_pipe[k]  <= 1'b0;
        r_exp_pipe[k]  <= {CH_W{1'b0}};
        r_mask_pipe[k] <= {CH_W{1'b0}};
        r_addr_pipe[k] <= {ADDR_W{1'b0}};
      end
    end else begin
      if (r_state == ST_RUN) r_dio <= r_mem_drive[r_addr];
      r_vld_pipe[0]  <= (r_state == ST_RUN);
      r_exp_pipe[0]  <= r_mem_exp[r_addr];
      r_mask_pipe[0] <= r_mem_mask[r_addr];
      r_addr_pipe[0] <= r_addr;
      for (int k = 1; k <= LAT; k++) begin
        r_vld_pipe[k]  <= r_vld_pipe[k-1];
        r_exp_pipe[k]  <= r_exp_pipe[k-1];
        r_mask_pipe[k] <= r_mask_pipe[k-1];
        r_addr_pipe[k] <= r_addr_pipe[k-1];
      end
    end
  end

  // Address sequencing, test configuration, error statistics and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr        <= {ADDR_W{1'b0}};
      r_num         <= {(ADDR_W + 1){1'b0}};
      r_mode        <= 2'd0;
      r_max         <= 32'd0;
      r_drain_cnt   <= 4'd0;
      r_busy        <= 1'b0;
      r_test_done   <= 1'b0;
      r_pass        <= 1'b0;
      r_aborted     <= 1'b0;
      r_err_count   <= {ERR_W{1'b0}};
      r_ffa         <= {ADDR_W{1'b0}};
      r_pass_count  <= 32'd0;
`ifdef TV_FAIL_CAPTURE_EN
      r_fail_resp   <= {CH_W{1'b0}};
      r_fail_expect <= {CH_W{1'b0}};
`endif
    end else begin
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_test_done <= (w_state_nxt == ST_DONE);
      if (w_start_ok) begin
        r_addr        <= {ADDR_W{1'b0}};
        r_num         <= i_num_vectors;
        r_mode        <= i_test_mode;
        r_max         <= i_max_cycles;
        r_drain_cnt   <= 4'd0;
        // An empty test goes straight to DONE and reports a pass.
        r_pass        <= (i_num_vectors == {(ADDR_W + 1){1'b0}});
        r_aborted     <= 1'b0;
        r_err_count   <= {ERR_W{1'b0}};
        r_ffa         <= {ADDR_W{1'b0}};
        r_pass_count  <= 32'd0;
`ifdef TV_FAIL_CAPTURE_EN
        r_fail_resp   <= {CH_W{1'b0}};
        r_fail_expect <= {CH_W{1'b0}};
`endif
      end else begin
        if (r_state == ST_RUN) begin
          if (w_pass_end) begin
            r_addr       <= {ADDR_W{1'b0}};
            r_pass_count <= r_pass_count + 32'd1;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
          if (i_abort) r_aborted <= 1'b1;
        end
        // Compares keep retiring in DRAIN.
        if (w_cmp_fail) begin
          if (r_err_count != {ERR_W{1'b1}}) r_err_count <= r_err_count + ERR_W'(1);
          if (w_first_fail) begin
            r_ffa         <= r_addr_pipe[LAT];
`ifdef TV_FAIL_CAPTURE_EN
            r_fail_resp   <= i_dut_resp;
            r_fail_expect <= r_exp_pipe[LAT];
`endif
          end
        end
        if (r_state == ST_DRAIN) begin
          r_drain_cnt <= r_drain_cnt + 4'd1;
          // The last in-flight compare landed on the previous edge.
          if (w_drain_last) r_pass <= (r_err_count == {ERR_W{1'b0}}) && !r_aborted;
        end else begin
          r_drain_cnt <= 4'd0;
        end
      end
    end
  end

  assign o_dut_dio         = r_dio;
  assign o_busy            = r_busy;
  assign o_test_done       = r_test_done;
  assign o_pass            = r_pass;
  assign o_aborted         = r_aborted;
  assign o_error_count     = r_err_count;
  assign o_first_fail_addr = r_ffa;
  assign o_pass_count      = r_pass_count;
`ifdef TV_FAIL_CAPTURE_EN
  assign o_fail_resp       = r_fail_resp;
  assign o_fail_expect     = r_fail_expect;
`endif

endmodule

// File: tb/tb_tv_sequencer.sv
// Self-checking bench for tv_sequencer. The DUT response is a loopback of
// o_dut_dio delayed by two cycles, and bit 5 can be flipped for selected
// vectors. A second instance with ERR_W=4 shares all inputs so that the
// saturating counter can be checked.
module tb_tv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_drive, wr_expect, wr_mask;
  logic        start, abort;
  logic [1:0]  mode;
  logic [10:0] nvec;
  logic [31:0] maxc;
  logic [31:0] dut_resp;

  logic [31:0] dio_a, dio_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b, ab_a, ab_b;
  logic [15:0] errc_a;
  logic [3:0]  errc_b;
  logic [9:0]  ffa_a, ffa_b;
  logic [31:0] pc_a, pc_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] h0 = 32'd0, h1 = 32'd0, h2 = 32'd0;
  int          cur_n = 0;
  logic [31:0] inj = 32'd0;

  always #5 clk = ~clk;

  tv_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_drive(wr_drive), .i_wr_expect(wr_expect), .i_wr_mask(wr_mask),
    .i_start(start), .i_abort(abort), .i_test_mode(mode), .i_num_vectors(nvec),
    .i_max_cycles(maxc), .i_dut_resp(dut_resp), .o_dut_dio(dio_a), .o_busy(busy_a),
    .o_test_done(done_a), .o_pass(pass_a), .o_aborted(ab_a), .o_error_count(errc_a),
    .o_first_fail_addr(ffa_a), .o_pass_count(pc_a)
  );

  tv_sequencer #(.ERR_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_drive(wr_drive), .i_wr_expect(wr_expect), .i_wr_mask(wr_mask),
    .i_start(start), .i_abort(abort), .i_test_mode(mode), .i_num_vectors(nvec),
    .i_max_cycles(maxc), .i_dut_resp(dut_resp), .o_dut_dio(dio_b), .o_busy(busy_b),
    .o_test_done(done_b), .o_pass(pass_b), .o_aborted(ab_b), .o_error_count(errc_b),
    .o_first_fail_addr(ffa_b), .o_pass_count(pc_b)
  );

  typedef struct {
    logic [1:0]  mode;
    int          n;
    logic [31:0] maxc;
    logic [31:0] mask;
    bit          inv;
    logic [31:0] inj;
    int          lat;
    int          err;
    int          err_sat;
    int          ffa;
    bit          pass;
    int          pc;
  } vec_t;

  vec_t tbl [0:5];

  function automatic logic [31:0] pat(input int i);
    return 32'h3C00_0011 + (32'(i) * 32'h0001_0101);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: sample #1 after the edge, then update the loopback response.
  task automatic tick();
    logic [31:0] r;
    @(posedge clk);
    #1;
    h2 = h1; h1 = h0; h0 = dio_a;
    r = h2;
    for (int j = 0; j < cur_n; j++) begin
      if (inj[j] && (h2 == pat(j))) r[5] = ~r[5];
    end
    dut_resp = r;
  endtask

  task automatic load(input int n, input logic [31:0] m, input bit inv);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_addr = 10'(i); wr_drive = pat(i);
      wr_expect = inv ? ~pat(i) : pat(i); wr_mask = m;
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [1:0] md, input int n, input logic [31:0] mc);
    mode = md; nvec = 11'(n); maxc = mc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done_a && cyc < 300) begin
      tick();
      cyc++;
    end
    chk("done_seen", {63'd0, done_a}, 64'd1);
  endtask

  initial begin
    int cyc;
    logic seen;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 10'd0; wr_drive = 32'd0; wr_expect = 32'd0;
    wr_mask = 32'd0; start = 1'b0; abort = 1'b0; mode = 2'd0; nvec = 11'd0;
    maxc = 32'd0; dut_resp = 32'd0;
    #22;
    chk("rst_dio", {32'd0, dio_a}, 64'd0);
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_done", {63'd0, done_a}, 64'd0);
    chk("rst_pass", {63'd0, pass_a}, 64'd0);
    chk("rst_err", {48'd0, errc_a}, 64'd0);
    chk("rst_pc", {32'd0, pc_a}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    //              mode  n   maxc   mask           inv inj     lat err sat ffa pass pc
    tbl[0] = '{2'd0, 4,  32'd1, 32'hFFFF_FFFF, 1'b0, 32'h0, 9,  0,  0,  0,  1'b1, 1};
    tbl[1] = '{2'd1, 4,  32'd3, 32'hFFFF_FFFF, 1'b0, 32'h4, 17, 3,  3,  2,  1'b0, 3};
    tbl[2] = '{2'd1, 4,  32'd3, 32'hFFFF_FFDF, 1'b0, 32'h4, 17, 0,  0,  0,  1'b1, 3};
    tbl[3] = '{2'd2, 8,  32'd1, 32'hFFFF_FFFF, 1'b0, 32'h6, 10, 2,  2,  1,  1'b0, 0};
    tbl[4] = '{2'd1, 4,  32'd0, 32'hFFFF_FFFF, 1'b0, 32'h0, 9,  0,  0,  0,  1'b1, 1};
    tbl[5] = '{2'd0, 20, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'h0, 25, 20, 15, 0,  1'b0, 1};

    for (int t = 0; t < 6; t++) begin
      load(tbl[t].n, tbl[t].mask, tbl[t].inv);
      cur_n = tbl[t].n; inj = tbl[t].inj;
      go(tbl[t].mode, tbl[t].n, tbl[t].maxc);
      wait_done(1, cyc);
      chk($sformatf("t%0d_latency", t), 64'(cyc), 64'(tbl[t].lat));
      chk($sformatf("t%0d_err", t), {48'd0, errc_a}, 64'(tbl[t].err));
      chk($sformatf("t%0d_err_sat", t), {60'd0, errc_b}, 64'(tbl[t].err_sat));
      chk($sformatf("t%0d_ffa", t), {54'd0, ffa_a}, 64'(tbl[t].ffa));
      chk($sformatf("t%0d_pass", t), {63'd0, pass_a}, {63'd0, tbl[t].pass});
      chk($sformatf("t%0d_pc", t), {32'd0, pc_a}, 64'(tbl[t].pc));
      chk($sformatf("t%0d_aborted", t), {63'd0, ab_a}, 64'd0);
      inj = 32'd0;
      tick(); tick();
    end

    // Empty test right after a failing one.
    go(2'd0, 0, 32'd1);
    wait_done(1, cyc);
    chk("zero_latency_le2", {63'd0, (cyc >= 1 && cyc <= 2)}, 64'd1);
    chk("zero_pass", {63'd0, pass_a}, 64'd1);
    chk("zero_err", {48'd0, errc_a}, 64'd0);
    chk("zero_pc", {32'd0, pc_a}, 64'd0);
    tick();

    // Replay order, writes and start ignored while busy, dio hold.
    load(4, 32'hFFFF_FFFF, 1'b0);
    cur_n = 4;
    go(2'd0, 4, 32'd1);
    chk("seq_busy", {63'd0, busy_a}, 64'd1);
    tick();
    chk("seq_dio0", {32'd0, dio_a}, {32'd0, pat(0)});
    wr_en = 1'b1; wr_addr = 10'd0; wr_drive = 32'hDEAD_BEEF; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    chk("seq_dio1", {32'd0, dio_a}, {32'd0, pat(1)});
    tick();
    chk("seq_dio2", {32'd0, dio_a}, {32'd0, pat(2)});
    tick();
    chk("seq_dio3", {32'd0, dio_a}, {32'd0, pat(3)});
    wait_done(5, cyc);
    chk("seq_latency", 64'(cyc), 64'd9);
    tick();
    chk("seq_done_pulse", {63'd0, done_a}, 64'd0);
    chk("seq_idle", {63'd0, busy_a}, 64'd0);
    chk("seq_dio_hold", {32'd0, dio_a}, {32'd0, pat(3)});
    go(2'd0, 4, 32'd1);
    tick();
    chk("seq_write_ignored", {32'd0, dio_a}, {32'd0, pat(0)});
    wait_done(2, cyc);
    tick();

    // Continuous mode, abort after 10 cycles.
    go(2'd3, 4, 32'd0);
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(0, cyc);
    chk("abort_drain", 64'(cyc), 64'd4);
    chk("abort_flag", {63'd0, ab_a}, 64'd1);
    chk("abort_pass", {63'd0, pass_a}, 64'd0);
    chk("abort_pc", {32'd0, pc_a}, 64'd2);
    tick(); tick();
    go(2'd0, 4, 32'd1);
    chk("restart_clears_abort", {63'd0, ab_a}, 64'd0);
    wait_done(1, cyc);
    chk("restart_pass", {63'd0, pass_a}, 64'd1);
    tick();

    // Abort in IDLE is ignored; abort together with start lets start win.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", {63'd0, busy_a}, 64'd0);
    chk("idle_abort_flag", {63'd0, ab_a}, 64'd0);
    abort = 1'b1;
    go(2'd0, 4, 32'd1);
    abort = 1'b0;
    chk("start_wins_busy", {63'd0, busy_a}, 64'd1);
    wait_done(1, cyc);
    chk("start_wins_aborted", {63'd0, ab_a}, 64'd0);
    chk("start_wins_pass", {63'd0, pass_a}, 64'd1);
    tick();

    // Asynchronous reset in the middle of a run.
    go(2'd3, 4, 32'd0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dio", {32'd0, dio_a}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy_a}, 64'd0);
    chk("mid_rst_busy_sat", {63'd0, busy_b}, 64'd0);
    chk("mid_rst_pc", {32'd0, pc_a}, 64'd0);
    chk("mid_rst_flags", {60'd0, pass_a, ab_a, pass_b, ab_b}, 64'd0);
    chk("mid_rst_err", {38'd0, errc_b, ffa_a, errc_a[11:0]}, 64'd0);
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | done_a | done_b;
    end
    chk("mid_rst_no_done", {63'd0, seen}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {63'd0, busy_a}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
